// File: rtl/bayer_pkg.sv
// Shared types and default geometry for the Bayer window producer/consumer pair.
// Greyscale-stage users import this to agree on pixel and coordinate widths.
package bayer_pkg;

  localparam int DATA_W  = 12;
  localparam int LINE_W  = 1280;
  localparam int FRAME_H = 960;
  localparam int CW      = 11;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [CW-1:0]     coord_t;

endpackage

// File: rtl/bayer_line_ram.sv
// Single-port synchronous line buffer, read-before-write, shaped for block RAM inference.
module line_ram #(
  parameter int DEPTH = 1280,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register; a reset would stop block RAM inference.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/bayer_line_tap.sv
// Raster stream to vertically aligned taps: tap0 = pixel one line above, tap1 = current pixel.
module bayer_line_tap
  import bayer_pkg::*;
#(
  parameter int DATA_W  = bayer_pkg::DATA_W,
  parameter int LINE_W  = bayer_pkg::LINE_W,
  parameter int FRAME_H = bayer_pkg::FRAME_H,
  parameter int CW      = bayer_pkg::CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] tap0,
  output logic [DATA_W-1:0] tap1,
  output logic              tap_valid,
  output logic [CW-1:0]     x,
  output logic [CW-1:0]     y,
  output logic              eol,
  output logic              eof
);

  localparam int            AW     = $clog2(LINE_W);
  localparam logic [CW-1:0] X_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(FRAME_H - 1);

  logic [CW-1:0]     x_cnt, y_cnt;
  logic [CW-1:0]     eff_x, eff_y;
  logic              x_last, y_last, row_ok;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tap0_hold;

  // sof forces the accepted pixel to (0,0) regardless of where the counters stand.
  assign eff_x  = sof ? '0 : x_cnt;
  assign eff_y  = sof ? '0 : y_cnt;
  assign x_last = (eff_x == X_LAST);
  assign y_last = (eff_y == Y_LAST);
  assign row_ok = (eff_y != '0);

  line_ram #(
    .DEPTH (LINE_W),
    .WIDTH (DATA_W)
  ) u_line_ram (
    .clk   (clk),
    .en    (pix_valid),
    .addr  (eff_x[AW-1:0]),
    .wdata (pix_in),
    .rdata (ram_rdata)
  );

  // The RAM read register updates on every accept, including row 0; tap0 must only
  // follow it in the cycle a tap is presented, otherwise it shows the captured value.
  assign tap0 = tap_valid ? ram_rdata : tap0_hold;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pix_valid) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : eff_y + 1'b1;
      end else begin
        x_cnt <= eff_x + 1'b1;
        y_cnt <= eff_y;
      end
    end else if (sof) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_valid <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      tap1      <= '0;
      x         <= '0;
      y         <= '0;
      tap0_hold <= '0;
    end else begin
      tap0_hold <= tap0;
      if (pix_valid) begin
        tap_valid <= row_ok;
        eol       <= row_ok && x_last;
        eof       <= x_last && y_last;
        if (row_ok) begin
          tap1 <= pix_in;
          x    <= eff_x;
          y    <= eff_y;
        end
      end else begin
        tap_valid <= 1'b0;
        eol       <= 1'b0;
        eof       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bayer_line_tap.sv
// Randomised scoreboard bench for bayer_line_tap on a 4x3 frame; the reference keeps a
// frame image and derives each tap from the pixel directly above in that image.
module tb_bayer_line_tap;

  localparam int DW = 12;
  localparam int LW = 4;
  localparam int FH = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_valid = 1'b0;
  logic          sof = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic [DW-1:0] tap0, tap1;
  logic          tap_valid, eol, eof;
  logic [CW-1:0] x, y;

  bayer_line_tap #(
    .DATA_W  (DW),
    .LINE_W  (LW),
    .FRAME_H (FH),
    .CW      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .tap0      (tap0),
    .tap1      (tap1),
    .tap_valid (tap_valid),
    .x         (x),
    .y         (y),
    .eol       (eol),
    .eof       (eof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] t0;
    logic [DW-1:0] t1;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          eol;
    logic          eof;
  } tap_t;

  tap_t          exp_q[$];
  logic [DW-1:0] img [FH][LW];
  int            pos = 0;
  // last tap the model presented; outputs must hold it while tap_valid is low
  logic [DW+DW+CW+CW-1:0] held = '0;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one comparison per cycle, popping whenever a tap is due.
  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0) begin
        tap_t e;
        e = exp_q.pop_front();
        check("tap", {tap_valid, tap0, tap1, x, y, eol, eof}, {1'b1, e});
        held = {e.t0, e.t1, e.x, e.y};
      end else begin
        check("idle_hold", {tap_valid, eol, eof, tap0, tap1, x, y}, {3'b000, held});
      end
    end
  end

  // Reference: frame position as a flat index; tap0 is the image pixel one row up.
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    int px, py;
    @(negedge clk);
    #1;
    pix_valid = v;
    sof       = s;
    pix_in    = d;
    if (s) pos = 0;
    if (v) begin
      px = pos % LW;
      py = pos / LW;
      if (py >= 1)
        exp_q.push_back('{t0: img[py-1][px], t1: d, x: CW'(px), y: CW'(py),
                          eol: (px == LW-1), eof: (px == LW-1) && (py == FH-1)});
      img[py][px] = d;
      pos = (pos + 1) % (LW * FH);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic frame(input int base, input bit gaps, input bit use_sof);
    for (int n = 0; n < LW * FH; n++) begin
      drive(1'b1, use_sof && (n == 0), DW'(base + n));
      if (gaps) drive(1'b0, 1'b0, DW'($urandom));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check("reset_outputs", {tap_valid, eol, eof, tap0, tap1, x, y}, '0);
    exp_q.delete();
    held = '0;
    pos  = 0;
    @(negedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {tap_valid, eol, eof, tap0, tap1, x, y}, '0);
    @(negedge clk);
    #3 rst = 1'b1;

    // continuous frame, then the same frame with alternating gaps
    frame(0, 1'b0, 1'b1);
    idle(2);
    frame(0, 1'b1, 1'b1);
    idle(2);

    // back-to-back frames wrap without a gap cycle
    frame(0, 1'b0, 1'b1);
    frame(100, 1'b0, 1'b1);
    idle(2);

    // resynchronising sof in the middle of row 1
    for (int n = 0; n < 6; n++) drive(1'b1, n == 0, DW'(n));
    drive(1'b1, 1'b1, DW'(6));
    for (int n = 7; n < 18; n++) drive(1'b1, 1'b0, DW'(n));
    idle(2);

    // sof without a pixel rewinds the counters
    for (int n = 0; n < 6; n++) drive(1'b1, n == 0, DW'(50 + n));
    drive(1'b0, 1'b1, '0);
    frame(60, 1'b0, 1'b0);
    idle(2);

    // reset mid-frame, then restart without sof from the reset counter state
    for (int n = 0; n < 10; n++) drive(1'b1, n == 0, DW'(n));
    idle(1);
    pulse_reset();
    frame(200, 1'b0, 1'b0);
    idle(2);

    // full-scale extremes across rows 0 and 1
    for (int n = 0; n < LW; n++) drive(1'b1, n == 0, (n % 2) ? 12'hFFF : 12'h000);
    for (int n = 0; n < LW; n++) drive(1'b1, 1'b0, (n % 2) ? 12'h000 : 12'hFFF);
    for (int n = 0; n < LW; n++) drive(1'b1, 1'b0, DW'($urandom));
    idle(2);

    // random data with random gaps and occasional random resync
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < LW * FH; n++) begin
        drive(1'b1, (n == 0) || ($urandom_range(0, 15) == 0), DW'($urandom));
        if ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0, DW'($urandom));
      end
    end
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
